// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_mode_e;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity_mode,
                                      input int stop_bits);
        return 1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
`timescale 1ns/1ps
// Bit-period divider: pulses tick on the last clk of every bit period.
// clear holds the count at zero so a new frame starts on a bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap on each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional
// parity, STOP_BITS stop bits. Optional macro UART_TX_HOLD_EN adds a
// one-entry holding register so frames can run back to back.
//
// Handshake: a word is accepted on a rising clk edge where both
// i_start_transmission and o_ready are high; i_data is sampled only then.
// Valid while o_ready is low is ignored and never disturbs the frame in flight.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_start_transmission,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_tx,
    output tx_state_e            dbg_state
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_e              state, state_nx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_idx;
    logic                   tick;
    logic                   baud_clear;
    logic                   accept;
    logic                   frame_end;
    logic                   launch;
    logic [DATA_BITS-1:0]   launch_word;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (PARITY_MODE == int'(PAR_ODD)) ? ~^word : ^word;
    endfunction

    // Divider is held cleared while idle so START lasts a full bit period.
    assign baud_clear = (state == IDLE);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (i_reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign accept    = i_start_transmission && o_ready;
    assign frame_end = (state == STOP) && tick && (stop_idx == STOP_LAST);

`ifdef UART_TX_HOLD_EN
    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;

    assign o_ready     = !hold_valid;
    // A new frame launches from IDLE or straight out of STOP; the held word wins.
    assign launch      = ((state == IDLE) || frame_end) && (hold_valid || accept);
    assign launch_word = hold_valid ? hold_data : i_data;

    // Holding register: fill on accept unless the word goes straight to the shifter.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept && !(launch && !hold_valid)) begin
            hold_valid <= 1'b1;
            hold_data  <= i_data;
        end else if (launch) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign o_ready     = (state == IDLE);
    assign launch      = (state == IDLE) && accept;
    assign launch_word = i_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and line/busy outputs.
    always_comb begin
        state_nx = state;
        o_tx     = 1'b1;
        o_busy   = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (launch) state_nx = START;
            end
            START: begin
                o_tx = 1'b0;
                if (tick) state_nx = DATA;
            end
            DATA: begin
                o_tx = shift_q[0];
                if (tick && (bit_idx == LAST_IDX)) begin
                    state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                o_tx = parity_q;
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (frame_end) state_nx = launch ? START : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Shift register, precomputed parity and bit/stop index counters.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (launch) begin
                shift_q  <= launch_word;
                parity_q <= parity_of(launch_word);
            end
            if ((state == START) && tick) begin
                bit_idx <= '0;
            end
            if ((state == DATA) && tick) begin
                shift_q <= shift_q >> 1;
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if ((state_nx == STOP) && (state != STOP)) begin
                stop_idx <= 1'b0;
            end else if ((state == STOP) && tick) begin
                stop_idx <= ~stop_idx;
            end
        end
    end

    assign dbg_state = state;

endmodule
